// File: rtl/pc_write_pkg.sv
// Shared encodings for the PC write unit: FSM states, exception causes,
// next-PC sources and the exception vector base.
package pc_write_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SAVE   = 2'b01,
        ST_VECTOR = 2'b10
    } exc_state_e;

    typedef enum logic [1:0] {
        CAUSE_UNDEF    = 2'b00,
        CAUSE_OVF      = 2'b01,
        CAUSE_DIV0     = 2'b10,
        CAUSE_MISALIGN = 2'b11
    } exc_cause_e;

    typedef enum logic [1:0] {
        SRC_ALU_RESULT = 2'b00,
        SRC_ALU_OUT    = 2'b01,
        SRC_JUMP       = 2'b10,
        SRC_EPC        = 2'b11
    } pc_src_e;

    localparam logic [31:0] VECTOR_BASE = 32'h0000_0080;

    // Handler entry points are spaced one word apart, indexed by cause.
    function automatic logic [31:0] vector_addr(input logic [1:0] cause);
        return VECTOR_BASE + {28'h000_0000, cause, 2'b00};
    endfunction

endpackage

// File: rtl/pc_write_unit_if.sv
// Control/datapath bundle between the core and the PC write unit.
interface pc_write_unit_if;

    logic        PCWrite;
    logic        PCWriteCond;
    logic [31:0] MuxPCWriteCondFio;
    logic [1:0]  PCSource;
    logic [31:0] AluResult;
    logic [31:0] AluOut;
    logic [25:0] InstrIndex;
    logic        ExcReq;
    logic [1:0]  ExcCause;
    logic [31:0] PCFio;
    logic [31:0] EPCFio;
    logic [1:0]  CauseFio;
    logic        ExcBusy;
    logic        ExcAck;
    logic [15:0] TakenCount;

    modport master (
        output PCWrite, PCWriteCond, MuxPCWriteCondFio, PCSource,
               AluResult, AluOut, InstrIndex, ExcReq, ExcCause,
        input  PCFio, EPCFio, CauseFio, ExcBusy, ExcAck, TakenCount
    );

    modport slave (
        input  PCWrite, PCWriteCond, MuxPCWriteCondFio, PCSource,
               AluResult, AluOut, InstrIndex, ExcReq, ExcCause,
        output PCFio, EPCFio, CauseFio, ExcBusy, ExcAck, TakenCount
    );

endinterface

// File: rtl/pc_write_unit_exc_sequencer.sv
// Three-state exception sequencer (IDLE -> SAVE -> VECTOR -> IDLE) with
// registered busy/ack flags.
module exc_sequencer
    import pc_write_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       exc_i,
    output exc_state_e state_o,
    output logic       exc_busy_o,
    output logic       exc_ack_o
);

    exc_state_e state_q, state_d;
    logic       busy_q, busy_d;
    logic       ack_q, ack_d;

    // Next-state logic; flags are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_i) begin
                    state_d = ST_SAVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE:   state_d = ST_VECTOR;
            ST_VECTOR: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        ack_d  = (state_d == ST_VECTOR);
    end

    // State and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign state_o    = state_q;
    assign exc_busy_o = busy_q;
    assign exc_ack_o  = ack_q;

endmodule

// File: rtl/pc_write_unit.sv
// Program-counter update with conditional branches, exception entry via
// EPC/cause capture, vectoring, and a taken-branch counter.
module pc_write_unit
    import pc_write_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    pc_write_unit_if.slave  bus
);

    exc_state_e  state_s;
    logic        exc_busy_s;
    logic        exc_ack_s;

    logic        we_s;
    logic        idle_s;
    logic        misaligned_s;
    logic        exc_s;
    logic        taken_s;
    logic [1:0]  cause_s;
    logic [31:0] next_pc_s;
    logic        unused_s;

    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [15:0] taken_q, taken_d;

    assign unused_s = ^bus.MuxPCWriteCondFio[31:1];

    exc_sequencer u_seq (
        .clk        (clk),
        .rst        (rst),
        .exc_i      (exc_s),
        .state_o    (state_s),
        .exc_busy_o (exc_busy_s),
        .exc_ack_o  (exc_ack_s)
    );

    // Write enable, next-PC select and exception detection; inputs are ignored outside IDLE.
    always_comb begin
        we_s = bus.PCWrite | (bus.PCWriteCond & bus.MuxPCWriteCondFio[0]);
        case (pc_src_e'(bus.PCSource))
            SRC_ALU_RESULT: next_pc_s = bus.AluResult;
            SRC_ALU_OUT:    next_pc_s = bus.AluOut;
            SRC_JUMP:       next_pc_s = {pc_q[31:28], bus.InstrIndex, 2'b00};
            SRC_EPC:        next_pc_s = epc_q;
            default:        next_pc_s = bus.AluResult;
        endcase
        idle_s       = (state_s == ST_IDLE);
        misaligned_s = we_s & (next_pc_s[1:0] != 2'b00);
        exc_s        = idle_s & (bus.ExcReq | misaligned_s);
        taken_s      = bus.PCWriteCond & bus.MuxPCWriteCondFio[0] & ~bus.PCWrite;
        if (bus.ExcReq) begin
            cause_s = bus.ExcCause;
        end else begin
            cause_s = CAUSE_MISALIGN;
        end
    end

    // Datapath next state: exception capture beats a normal load; SAVE loads the vector.
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        taken_d = taken_q;
        if (exc_s) begin
            epc_d   = pc_q - 32'd4;
            cause_d = cause_s;
        end else if (idle_s && we_s) begin
            pc_d = next_pc_s;
            if (taken_s) begin
                taken_d = taken_q + 16'd1;
            end else begin
                taken_d = taken_q;
            end
        end else if (state_s == ST_SAVE) begin
            pc_d = vector_addr(cause_q);
        end else begin
            pc_d = pc_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= 32'h0000_0000;
            epc_q   <= 32'h0000_0000;
            cause_q <= 2'b00;
            taken_q <= 16'h0000;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            taken_q <= taken_d;
        end
    end

    assign bus.PCFio      = pc_q;
    assign bus.EPCFio     = epc_q;
    assign bus.CauseFio   = cause_q;
    assign bus.TakenCount = taken_q;
    assign bus.ExcBusy    = exc_busy_s;
    assign bus.ExcAck     = exc_ack_s;

endmodule

// File: tb/tb_pc_write_unit.sv
// Directed plus randomized checks of pc_write_unit against a behavioural model.
module tb_pc_write_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_write_unit_if ifc ();

    pc_write_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    int          m_cause;
    int          m_taken;
    int          m_phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_epc = 32'd0; m_cause = 0; m_taken = 0; m_phase = 0;
    endtask

    // Spec-level model: phase counts the cycles spent in the exception sequence.
    task automatic model_edge();
        logic        we;
        logic [31:0] nxt;
        we = ifc.PCWrite | (ifc.PCWriteCond & ifc.MuxPCWriteCondFio[0]);
        case (ifc.PCSource)
            2'd0:    nxt = ifc.AluResult;
            2'd1:    nxt = ifc.AluOut;
            2'd2:    nxt = {m_pc[31:28], ifc.InstrIndex, 2'b00};
            default: nxt = m_epc;
        endcase
        if (m_phase == 0) begin
            if (ifc.ExcReq) begin
                m_epc = m_pc - 32'd4; m_cause = int'(ifc.ExcCause); m_phase = 1;
            end else if (we && nxt[1:0] != 2'b00) begin
                m_epc = m_pc - 32'd4; m_cause = 3; m_phase = 1;
            end else if (we) begin
                m_pc = nxt;
                if (ifc.PCWriteCond && ifc.MuxPCWriteCondFio[0] && !ifc.PCWrite)
                    m_taken = (m_taken + 1) % 65536;
            end
        end else if (m_phase == 1) begin
            m_pc = 32'h80 + 32'(4 * m_cause);
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    ifc.PCFio,               m_pc);
        chk({tag, ".epc"},   ifc.EPCFio,              m_epc);
        chk({tag, ".cause"}, {30'd0, ifc.CauseFio},   32'(m_cause));
        chk({tag, ".taken"}, {16'd0, ifc.TakenCount}, 32'(m_taken));
        chk({tag, ".busy"},  {31'd0, ifc.ExcBusy},    {31'd0, m_phase != 0});
        chk({tag, ".ack"},   {31'd0, ifc.ExcAck},     {31'd0, m_phase == 2});
    endtask

    task automatic drive(input logic pw, input logic pwc, input logic [31:0] cond,
                         input logic [1:0] src, input logic [31:0] res,
                         input logic [31:0] aout, input logic exc, input logic [1:0] cause);
        ifc.PCWrite = pw; ifc.PCWriteCond = pwc; ifc.MuxPCWriteCondFio = cond;
        ifc.PCSource = src; ifc.AluResult = res; ifc.AluOut = aout;
        ifc.ExcReq = exc; ifc.ExcCause = cause;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0);
    endtask

    task automatic tick(input string tag, input bit do_check);
        @(posedge clk);
        model_edge();
        #1;
        if (do_check) check_all(tag);
    endtask

    initial begin
        ifc.InstrIndex = 26'd0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        #4;

        // Unconditional write
        drive(1'b1, 1'b0, 32'd0, 2'd0, 32'h100, 32'd0, 1'b0, 2'd0); tick("ld100", 1'b1);
        drive(1'b1, 1'b0, 32'd0, 2'd0, 32'h104, 32'd0, 1'b0, 2'd0); tick("uncond", 1'b1);
        chk("uncond.pc_const", ifc.PCFio, 32'h104);
        chk("uncond.taken_const", {16'd0, ifc.TakenCount}, 32'd0);

        // Conditional branch taken / not taken
        drive(1'b0, 1'b1, 32'd1, 2'd1, 32'd0, 32'h200, 1'b0, 2'd0); tick("br_taken", 1'b1);
        chk("br_taken.pc_const", ifc.PCFio, 32'h200);
        chk("br_taken.cnt_const", {16'd0, ifc.TakenCount}, 32'd1);
        drive(1'b0, 1'b1, 32'hFFFF_FFFE, 2'd1, 32'd0, 32'h300, 1'b0, 2'd0); tick("br_not", 1'b1);
        chk("br_not.pc_const", ifc.PCFio, 32'h200);

        // Exception with a PCWrite attempted during SAVE
        drive(1'b1, 1'b0, 32'd0, 2'd0, 32'h108, 32'd0, 1'b0, 2'd0); tick("ld108", 1'b1);
        drive(1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd1); tick("exc_save", 1'b1);
        chk("exc_save.epc_const", ifc.EPCFio, 32'h104);
        chk("exc_save.cause_const", {30'd0, ifc.CauseFio}, 32'd1);
        drive(1'b1, 1'b0, 32'd0, 2'd0, 32'h400, 32'd0, 1'b1, 2'd2); tick("exc_vec", 1'b1);
        chk("exc_vec.pc_const", ifc.PCFio, 32'h84);
        chk("exc_vec.ack_const", {31'd0, ifc.ExcAck}, 32'd1);
        idle_inputs(); tick("exc_done", 1'b1);
        chk("exc_done.ack_const", {31'd0, ifc.ExcAck}, 32'd0);

        // Return from exception
        drive(1'b1, 1'b0, 32'd0, 2'd3, 32'd0, 32'd0, 1'b0, 2'd0); tick("eret", 1'b1);
        chk("eret.pc_const", ifc.PCFio, 32'h104);

        // Misaligned target
        drive(1'b1, 1'b0, 32'd0, 2'd0, 32'h102, 32'd0, 1'b0, 2'd0); tick("mis_save", 1'b1);
        chk("mis_save.pc_const", ifc.PCFio, 32'h104);
        chk("mis_save.cause_const", {30'd0, ifc.CauseFio}, 32'd3);
        idle_inputs(); tick("mis_vec", 1'b1);
        chk("mis_vec.pc_const", ifc.PCFio, 32'h8C);
        tick("mis_done", 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r0;
            logic [31:0] r1;
            r0 = $urandom;
            r1 = $urandom;
            if ($urandom_range(0, 7) != 0) r0[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) r1[1:0] = 2'b00;
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom,
                  2'($urandom_range(0, 3)), r0, r1,
                  1'($urandom_range(0, 15) == 0), 2'($urandom_range(0, 2)));
            ifc.InstrIndex = 26'($urandom);
            tick("rand", 1'b1);
        end
        ifc.InstrIndex = 26'd0;

        // Asynchronous reset while in VECTOR
        idle_inputs();
        while (m_phase != 0) tick("drain", 1'b1);
        drive(1'b1, 1'b0, 32'd0, 2'd0, 32'h500, 32'd0, 1'b0, 2'd0); tick("ld500", 1'b1);
        drive(1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd2); tick("r_save", 1'b1);
        idle_inputs(); tick("r_vec", 1'b1);
        chk("r_vec.ack_const", {31'd0, ifc.ExcAck}, 32'd1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        #2 rst = 1'b0;
        drive(1'b1, 1'b0, 32'd0, 2'd0, 32'h10, 32'd0, 1'b0, 2'd0); tick("post_rst", 1'b1);

        // TakenCount wrap-around
        for (int i = 0; i < 65534; i++) begin
            drive(1'b0, 1'b1, 32'd1, 2'd1, 32'd0, 32'(i * 4), 1'b0, 2'd0);
            tick("wrap_fill", 1'b0);
        end
        drive(1'b0, 1'b1, 32'd1, 2'd1, 32'd0, 32'h40, 1'b0, 2'd0); tick("wrap_ffff", 1'b1);
        chk("wrap_ffff.const", {16'd0, ifc.TakenCount}, 32'h0000_FFFF);
        drive(1'b0, 1'b1, 32'd1, 2'd1, 32'd0, 32'h44, 1'b0, 2'd0); tick("wrap_zero", 1'b1);
        chk("wrap_zero.const", {16'd0, ifc.TakenCount}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
